uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_core.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: TX/RX state enums and counter-width helper.
// The parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } txState_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop,
    RxWaitHigh
  } rxState_e;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous receive line.
// Both flops preset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxAsync_i,
  output logic rxSync_o
);

  logic [1:0] syncQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= 2'b11;
    end else begin
      syncQ <= {syncQ[0], rxAsync_i};
    end
  end

  assign rxSync_o = syncQ[1];

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with independent TX and RX FSMs on a single clock.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int unsigned CntW = cntWidth(CLKS_PER_BIT);
  localparam int unsigned IdxW = cntWidth(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD > 1) begin : genBadParam
    $error("uart_core: illegal parameter value");
  end

  // ---------------- Transmitter ----------------
  txState_e             txStateQ, txStateD;
  logic [CntW-1:0]      txCntQ, txCntD;
  logic [IdxW-1:0]      txIdxQ, txIdxD;
  logic                 txStopQ, txStopD;
  logic [DATA_BITS-1:0] txShiftQ, txShiftD;
  logic                 txOutQ, txOutD;
  logic                 txBitEnd;
`ifdef UART_PARITY_EN
  logic                 txParQ, txParD;
`endif

  assign txBitEnd = (txCntQ == CntLast);

  always_comb begin
    txStateD = txStateQ;
    txCntD   = txBitEnd ? '0 : txCntQ + CntOne;
    txIdxD   = txIdxQ;
    txStopD  = txStopQ;
    txShiftD = txShiftQ;
`ifdef UART_PARITY_EN
    txParD   = txParQ;
`endif
    unique case (txStateQ)
      TxIdle: begin
        txCntD = '0;
        if (tx_valid) begin
          txShiftD = tx_data;
`ifdef UART_PARITY_EN
          txParD   = ^tx_data ^ PARITY_ODD[0];
`endif
          txStateD = TxStart;
        end
      end
      TxStart: begin
        if (txBitEnd) begin
          txIdxD   = '0;
          txStateD = TxData;
        end
      end
      TxData: begin
        if (txBitEnd) begin
          txShiftD = txShiftQ >> 1;
          if (txIdxQ == IdxLast) begin
            txStopD = 1'b0;
`ifdef UART_PARITY_EN
            txStateD = TxParity;
`else
            txStateD = TxStop;
`endif
          end else begin
            txIdxD = txIdxQ + IdxOne;
          end
        end
      end
`ifdef UART_PARITY_EN
      TxParity: begin
        if (txBitEnd) begin
          txStateD = TxStop;
        end
      end
`endif
      TxStop: begin
        if (txBitEnd) begin
          if (txStopQ == StopLast) begin
            txStateD = TxIdle;
          end else begin
            txStopD = 1'b1;
          end
        end
      end
      default: txStateD = TxIdle;
    endcase

    // Line level is registered from the next state so tx_o is glitch-free.
    unique case (txStateD)
      TxStart:  txOutD = 1'b0;
      TxData:   txOutD = txShiftD[0];
`ifdef UART_PARITY_EN
      TxParity: txOutD = txParD;
`endif
      default:  txOutD = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txStateQ <= TxIdle;
      txCntQ   <= '0;
      txIdxQ   <= '0;
      txStopQ  <= 1'b0;
      txShiftQ <= '0;
      txOutQ   <= 1'b1;
`ifdef UART_PARITY_EN
      txParQ   <= 1'b0;
`endif
    end else begin
      txStateQ <= txStateD;
      txCntQ   <= txCntD;
      txIdxQ   <= txIdxD;
      txStopQ  <= txStopD;
      txShiftQ <= txShiftD;
      txOutQ   <= txOutD;
`ifdef UART_PARITY_EN
      txParQ   <= txParD;
`endif
    end
  end

  assign tx_o     = txOutQ;
  assign tx_ready = (txStateQ == TxIdle);

  // ---------------- Receiver ----------------
  logic                 rxS;
  rxState_e             rxStateQ, rxStateD;
  logic [CntW-1:0]      rxCntQ, rxCntD;
  logic [IdxW-1:0]      rxIdxQ, rxIdxD;
  logic [DATA_BITS-1:0] rxShiftQ, rxShiftD;
  logic [DATA_BITS-1:0] rxDataQ, rxDataD;
  logic                 rxValidQ, rxValidD;
  logic                 rxFrameErrQ, rxFrameErrD;
  logic                 rxSampleEnd;
`ifdef UART_PARITY_EN
  logic                 rxParQ, rxParD;
  logic                 rxParityErrQ, rxParityErrD;
`endif

  uart_rx_sync uRxSync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxAsync_i (rx_i),
    .rxSync_o  (rxS)
  );

  assign rxSampleEnd = (rxCntQ == CntLast);

  always_comb begin
    rxStateD    = rxStateQ;
    rxCntD      = rxSampleEnd ? '0 : rxCntQ + CntOne;
    rxIdxD      = rxIdxQ;
    rxShiftD    = rxShiftQ;
    rxDataD     = rxDataQ;
    rxValidD    = 1'b0;
    rxFrameErrD = rxFrameErrQ;
`ifdef UART_PARITY_EN
    rxParD       = rxParQ;
    rxParityErrD = rxParityErrQ;
`endif
    unique case (rxStateQ)
      RxIdle: begin
        rxCntD = '0;
        if (!rxS) begin
          rxStateD = RxStart;
        end
      end
      RxStart: begin
        // Mid-start re-check; later samples are one full bit apart from here.
        if (rxCntQ == CntHalf) begin
          rxCntD   = '0;
          rxIdxD   = '0;
          rxStateD = rxS ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rxSampleEnd) begin
          rxShiftD = {rxS, rxShiftQ[DATA_BITS-1:1]};
          if (rxIdxQ == IdxLast) begin
`ifdef UART_PARITY_EN
            rxStateD = RxParity;
`else
            rxStateD = RxStop;
`endif
          end else begin
            rxIdxD = rxIdxQ + IdxOne;
          end
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        if (rxSampleEnd) begin
          rxParD   = rxS;
          rxStateD = RxStop;
        end
      end
`endif
      RxStop: begin
        if (rxSampleEnd) begin
          rxDataD     = rxShiftQ;
          rxFrameErrD = ~rxS;
          rxValidD    = 1'b1;
`ifdef UART_PARITY_EN
          rxParityErrD = ^rxShiftQ ^ rxParQ ^ PARITY_ODD[0];
`endif
          rxStateD = rxS ? RxIdle : RxWaitHigh;
        end
      end
      RxWaitHigh: begin
        rxCntD = '0;
        if (rxS) begin
          rxStateD = RxIdle;
        end
      end
      default: rxStateD = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxStateQ    <= RxIdle;
      rxCntQ      <= '0;
      rxIdxQ      <= '0;
      rxShiftQ    <= '0;
      rxDataQ     <= '0;
      rxValidQ    <= 1'b0;
      rxFrameErrQ <= 1'b0;
`ifdef UART_PARITY_EN
      rxParQ       <= 1'b0;
      rxParityErrQ <= 1'b0;
`endif
    end else begin
      rxStateQ    <= rxStateD;
      rxCntQ      <= rxCntD;
      rxIdxQ      <= rxIdxD;
      rxShiftQ    <= rxShiftD;
      rxDataQ     <= rxDataD;
      rxValidQ    <= rxValidD;
      rxFrameErrQ <= rxFrameErrD;
`ifdef UART_PARITY_EN
      rxParQ       <= rxParD;
      rxParityErrQ <= rxParityErrD;
`endif
    end
  end

  assign rx_data      = rxDataQ;
  assign rx_valid     = rxValidQ;
  assign rx_frame_err = rxFrameErrQ;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rxParityErrQ;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX waveform, loopback scoreboard, RX error cases, reset.
module tb_uart_core;

  localparam int unsigned Cpb = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NB = 1 + 8 + P + 1;
  localparam logic ParOdd = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxDrive = 1'b1;
  logic       loopback = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_o, tx_ready, rx_valid, rx_frame_err, rx_parity_err;
  logic [7:0] rx_data;
  logic       rx_i;

  assign rx_i = loopback ? tx_o : rxDrive;

  uart_core #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (8),
    .STOP_BITS    (1),
    .PARITY_ODD   (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_i          (rx_i),
    .tx_o          (tx_o),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  int nErr = 0;
  int nChk = 0;
  int cycleCnt = 0;
  int rxValidCnt = 0;
  int lastValidCyc = 0;
  logic spacingOn = 1'b0;
  logic haveLast = 1'b0;
  // Expected words: {frameErr, parityErr, data}
  logic [9:0] expQ[$];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic expTxBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (P == 1 && idx == 9) return ^d ^ ParOdd;
    return 1'b1;
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && rx_valid) begin
      rxValidCnt++;
      checkVal("rxExpected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkVal("rxData", rx_data, e[7:0]);
        checkVal("rxParityErr", rx_parity_err, e[8]);
        checkVal("rxFrameErr", rx_frame_err, e[9]);
      end
      if (spacingOn && haveLast) checkVal("rxSpacing", cycleCnt - lastValidCyc, NB * Cpb + 1);
      lastValidCyc = cycleCnt;
      haveLast = 1'b1;
    end
  end

  task automatic waitDrain(input string tag);
    int b = 0;
    while (expQ.size() != 0 && b < 800) begin
      @(negedge clk);
      b++;
    end
    checkVal(tag, expQ.size(), 0);
  endtask

  task automatic driveRx(input logic [7:0] d, input logic flipPar, input int stopLowBits);
    @(negedge clk);
    rxDrive = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxDrive = d[i];
      repeat (Cpb) @(negedge clk);
    end
    if (P == 1) begin
      rxDrive = ^d ^ ParOdd ^ flipPar;
      repeat (Cpb) @(negedge clk);
    end
    if (stopLowBits > 0) begin
      rxDrive = 1'b0;
      repeat (stopLowBits * Cpb) @(negedge clk);
    end
    rxDrive = 1'b1;
    repeat (Cpb) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nChk);
    $fatal(1);
  end

  initial begin
    int readyLow;
    int cnt0;
    int budget;
    logic [7:0] words [3];
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h55;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstTxO", tx_o, 1);
    checkVal("rstTxReady", tx_ready, 1);
    checkVal("rstRxValid", rx_valid, 0);
    checkVal("rstRxData", rx_data, 0);
    checkVal("rstErrs", {rx_frame_err, rx_parity_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Transmit 0xA5, check every cycle of the frame
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data = 8'hFF;
    readyLow = 0;
    for (int k = 0; k < int'(NB * Cpb); k++) begin
      checkVal($sformatf("txBit%0d", k / Cpb), tx_o, expTxBit(8'hA5, k / int'(Cpb)));
      if (!tx_ready) readyLow++;
      @(posedge clk);
      #1;
    end
    checkVal("txReadyLowCycles", readyLow, NB * Cpb);
    checkVal("txIdleReady", tx_ready, 1);
    checkVal("txIdleLine", tx_o, 1);

    // Loopback back-to-back with tx_valid held
    loopback = 1'b1;
    repeat (4) @(negedge clk);
    spacingOn = 1'b1;
    haveLast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      budget = 0;
      @(negedge clk);
      while (!tx_ready && budget < 400) begin
        @(negedge clk);
        budget++;
      end
      checkVal("lbReadyTimeout", 32'(budget < 400), 1);
      tx_data = words[i];
      tx_valid = 1'b1;
      expQ.push_back({2'b00, words[i]});
      @(posedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    waitDrain("lbDrain");
    spacingOn = 1'b0;
    repeat (20) @(negedge clk);
    loopback = 1'b0;
    repeat (4) @(negedge clk);

    // False start
    cnt0 = rxValidCnt;
    rxDrive = 1'b0;
    repeat (5) @(negedge clk);
    rxDrive = 1'b1;
    repeat (40) @(negedge clk);
    checkVal("falseStartNoValid", rxValidCnt - cnt0, 0);
    expQ.push_back({2'b00, 8'h5A});
    driveRx(8'h5A, 1'b0, 0);
    waitDrain("afterFalseStart");

    // Stop bit held low for three bit times
    cnt0 = rxValidCnt;
    expQ.push_back({2'b10, 8'h3C});
    driveRx(8'h3C, 1'b0, 3);
    repeat (3 * Cpb) @(negedge clk);
    checkVal("breakOneWord", rxValidCnt - cnt0, 1);
    checkVal("breakDrain", expQ.size(), 0);
    expQ.push_back({2'b00, 8'h81});
    driveRx(8'h81, 1'b0, 0);
    waitDrain("afterBreak");

`ifdef UART_PARITY_EN
    loopback = 1'b1;
    repeat (4) @(negedge clk);
    expQ.push_back({2'b00, 8'h07});
    tx_data = 8'h07;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (9 * Cpb + 8) @(posedge clk);
    #1;
    checkVal("txParityBit", tx_o, 1);
    waitDrain("parityLoop");
    repeat (20) @(negedge clk);
    loopback = 1'b0;
    expQ.push_back({2'b01, 8'h07});
    driveRx(8'h07, 1'b1, 0);
    waitDrain("parityFlip");
`endif

    // Asynchronous reset in the middle of a loopback frame
    loopback = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (3 * Cpb) @(posedge clk);
    #1;
    checkVal("preResetTxLow", tx_o, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("asyncRstTxO", tx_o, 1);
    checkVal("asyncRstRxData", rx_data, 0);
    checkVal("asyncRstRxValid", rx_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt0 = rxValidCnt;
    @(posedge clk);
    #1;
    checkVal("postRstReady", tx_ready, 1);
    repeat (400) @(negedge clk);
    checkVal("postRstNoValid", rxValidCnt - cnt0, 0);
    checkVal("postRstLine", tx_o, 1);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
